// File: rtl/tconv2d_zero_insert_pad_stage.sv
// -----------------------------------------------------------------------------
// tconv2d_zero_insert_pad_stage
//
// Front end of the transposed-conv-2D pipeline. Turns a raster input map into
// the equivalent direct-convolution operand map: STRIDE-1 zeros are inserted
// between input pixels along both axes and an EDGE-wide zero border is wrapped
// around the result, so the next stage can run a plain dilated convolution.
// One frame of H_EXT x W_EXT beats is produced per start.
//
// Optional feature macro: TZI_LAST_CHECK_EN
//   defined   -> s_last is compared against the pixel count; err is a sticky
//                framing-error flag (cleared only by reset).
//   undefined -> s_last is ignored and err is tied to 0.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready   input pixel handshake (s_ready is combinational)
//   s_data, s_last    input pixel (raster order) and end-of-frame marker
//   m_valid/m_ready   output beat handshake
//   m_data            extended-map pixel, raster order
//   m_sof/m_eol/m_eof first beat / last column / last beat of the extended map
//   busy              high while a frame is being walked
//   err               sticky framing error
// -----------------------------------------------------------------------------
module tconv2d_zero_insert_pad_stage #(
  parameter int DATA_W   = 32,
  parameter int H_IN     = 8,
  parameter int W_IN     = 16,
  parameter int STRIDE   = 2,
  parameter int KERNEL   = 3,
  parameter int PADDING  = 1,
  parameter int DILATION = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              err
);

  localparam int EDGE  = DILATION * (KERNEL - 1) - PADDING;
  localparam int H_EXT = (H_IN - 1) * STRIDE + 1 + 2 * EDGE;
  localparam int W_EXT = (W_IN - 1) * STRIDE + 1 + 2 * EDGE;
  localparam int R_W   = $clog2(H_EXT + 1);
  localparam int C_W   = $clog2(W_EXT + 1);
  localparam int P_W   = $clog2(STRIDE + 1);

  localparam logic [R_W-1:0] R_LAST = R_W'(H_EXT - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(W_EXT - 1);
  localparam logic [R_W-1:0] R_EDGE = R_W'(EDGE);
  localparam logic [C_W-1:0] C_EDGE = C_W'(EDGE);
  localparam logic [R_W-1:0] R_NIN  = R_W'(H_IN);
  localparam logic [C_W-1:0] C_NIN  = C_W'(W_IN);
  localparam logic [P_W-1:0] P_LAST = P_W'(STRIDE - 1);

  if (EDGE < 0) begin : g_edge_check
    $error("tconv2d_zero_insert_pad_stage: DILATION*(KERNEL-1)-PADDING must be >= 0");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state;
  logic [R_W-1:0] r_cnt, r_in;
  logic [C_W-1:0] c_cnt, c_in;
  logic [P_W-1:0] r_ph, c_ph;   // position within the current stride period
  logic           fin;          // eof beat loaded, waiting for it to drain

  logic row_site, col_site, site, adv, load, last_col, last_row;

  // Phase counters only start once the border is crossed, so phase 0 with an
  // in-range index is exactly an input site -- no divide or modulo needed.
  assign row_site = (r_cnt >= R_EDGE) && (r_ph == '0) && (r_in < R_NIN);
  assign col_site = (c_cnt >= C_EDGE) && (c_ph == '0) && (c_in < C_NIN);
  assign site     = row_site && col_site;
  assign last_col = (c_cnt == C_LAST);
  assign last_row = (r_cnt == R_LAST);

  assign adv     = !m_valid || m_ready;
  assign load    = (state == RUN) && !fin && adv;
  assign s_ready = load && site;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values; blocking here would create
  // ordering-dependent simulation and a mismatch against synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      fin     <= 1'b0;
      r_cnt   <= '0;
      r_in    <= '0;
      r_ph    <= '0;
      c_cnt   <= '0;
      c_in    <= '0;
      c_ph    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The triggering pixel stays on the input; it is consumed in RUN.
          if (s_valid) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (m_valid && m_ready && m_eof) begin
            state   <= IDLE;
            busy    <= 1'b0;
            fin     <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
          end else if (load) begin
            if (site && !s_valid) begin
              // Input site with no pixel yet: bubble and hold the position.
              m_valid <= 1'b0;
            end else begin
              m_valid <= 1'b1;
              m_data  <= site ? s_data : '0;
              m_sof   <= (r_cnt == '0) && (c_cnt == '0);
              m_eol   <= last_col;
              m_eof   <= last_col && last_row;
              if (last_col) begin
                c_cnt <= '0;
                c_ph  <= '0;
                c_in  <= '0;
                if (last_row) begin
                  r_cnt <= '0;
                  r_ph  <= '0;
                  r_in  <= '0;
                  fin   <= 1'b1;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt >= R_EDGE) begin
                    if (r_ph == P_LAST) begin
                      r_ph <= '0;
                      r_in <= r_in + 1'b1;
                    end else begin
                      r_ph <= r_ph + 1'b1;
                    end
                  end
                end
              end else begin
                c_cnt <= c_cnt + 1'b1;
                if (c_cnt >= C_EDGE) begin
                  if (c_ph == P_LAST) begin
                    c_ph <= '0;
                    c_in <= c_in + 1'b1;
                  end else begin
                    c_ph <= c_ph + 1'b1;
                  end
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TZI_LAST_CHECK_EN
  localparam int                N_W    = $clog2(H_IN * W_IN + 1);
  localparam logic [N_W-1:0]    N_LAST = N_W'(H_IN * W_IN - 1);

  logic [N_W-1:0] pix_cnt;
  logic           take, is_last;

  assign take    = s_valid && s_ready;
  assign is_last = (pix_cnt == N_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      err     <= 1'b0;
    end else if (take) begin
      pix_cnt <= is_last ? '0 : pix_cnt + 1'b1;
      if (s_last != is_last) err <= 1'b1;
    end
  end
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_tconv2d_zero_insert_pad_stage.sv
// -----------------------------------------------------------------------------
// Bench for tconv2d_zero_insert_pad_stage with H_IN=2 W_IN=3 S=2 K=3 P=1 D=2
// (EDGE=3, 9x11 extended map). Each table row describes one stimulus scenario
// together with the outputs it must produce; a scoreboard queue holds the
// expected beats built from an independent position model.
// -----------------------------------------------------------------------------
module tb_tconv2d_zero_insert_pad_stage;

  localparam int DW    = 32;
  localparam int EDGE  = 3;
  localparam int H_EXT = 9;
  localparam int W_EXT = 11;
  localparam int NPIX  = 6;
  localparam int NBEAT = H_EXT * W_EXT;

`ifdef TZI_LAST_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof, m_eol, m_eof, busy, err;

  always #5 clk = ~clk;

  tconv2d_zero_insert_pad_stage #(
    .DATA_W(DW), .H_IN(2), .W_IN(3), .STRIDE(2),
    .KERNEL(3), .PADDING(1), .DILATION(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .err(err)
  );

  typedef struct {
    string name;
    int    base;          // value of first input pixel
    int    ready_pct;     // m_ready probability in percent
    int    n_frames;
    int    stall_pix;     // pixel index held back (-1: none)
    int    stall_beat;    // hold it until this many beats were taken
    int    bad_last_pix;  // extra s_last on this pixel (-1: none)
    int    abort_at;      // stop after this many beats (-1: run to end)
    int    exp_beats;
    int    exp_busy_gaps;
    int    exp_stall_low;
    bit    exp_err;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [34:0] sb_q[$];
  bit err_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {57'd0, s_ready, m_valid, m_sof, m_eol, m_eof, busy, err}, 64'd0);
    check({name, "_data"}, {32'd0, m_data}, 64'd0);
  endtask

  // Independent model of the extended map: division/modulo site test.
  task automatic push_frame(input int first_val);
    for (int r = 0; r < H_EXT; r++) begin
      for (int c = 0; c < W_EXT; c++) begin
        bit real_site;
        logic [DW-1:0] v;
        real_site = (r >= EDGE) && ((r - EDGE) % 2 == 0) && ((r - EDGE) / 2 < 2) &&
                    (c >= EDGE) && ((c - EDGE) % 2 == 0) && ((c - EDGE) / 2 < 3);
        v = real_site ? DW'(first_val + ((r - EDGE) / 2) * 3 + (c - EDGE) / 2) : '0;
        sb_q.push_back({v, (r == 0 && c == 0), (c == W_EXT - 1),
                        (r == H_EXT - 1 && c == W_EXT - 1)});
      end
    end
  endtask

  task automatic run_case(input vec_t v);
    int pix = 0, out_cnt = 0, cyc = 0, stall_left = 5;
    int stall_low = 0, busy_gaps = 0, err_bad = 0, target;
    bit stalled_now, done = 0, prev_hold = 0, err_pending = 0;
    logic [35:0] prev_out = '0;
    logic [34:0] exp;
    int n_pix;

    n_pix  = NPIX * v.n_frames;
    target = (v.abort_at >= 0) ? v.abort_at : v.n_frames * NBEAT;
    for (int f = 0; f < v.n_frames; f++) push_frame(v.base + f * NPIX);

    while (!done) begin
      @(negedge clk);
      if (err_pending) err_model = 1'b1;
      err_pending = 1'b0;
      if (err !== err_model) err_bad++;
      if (prev_hold)
        check({v.name, "_hold"}, {28'd0, m_valid, m_data, m_sof, m_eol, m_eof},
              {28'd0, prev_out});

      stalled_now = 1'b0;
      if (pix == v.stall_pix && out_cnt >= v.stall_beat && stall_left > 0) begin
        stall_left--;
        stalled_now = 1'b1;
      end
      s_valid = (pix < n_pix) &&
                !(pix == v.stall_pix && (out_cnt < v.stall_beat || stalled_now));
      s_data  = DW'(v.base + pix);
      s_last  = ((pix % NPIX) == NPIX - 1) || (pix == v.bad_last_pix);
      m_ready = ($urandom_range(99) < v.ready_pct);
      #1;

      if (stalled_now && !m_valid) stall_low++;
      if (out_cnt > 0 && !busy) busy_gaps++;
      if (s_valid && s_ready) begin
        if (LC && (s_last != ((pix % NPIX) == NPIX - 1))) err_pending = 1'b1;
        pix++;
      end
      prev_hold = m_valid && !m_ready;
      prev_out  = {m_valid, m_data, m_sof, m_eol, m_eof};
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check({v.name, "_unexpected_beat"}, {29'd0, m_data, m_sof, m_eol, m_eof}, 64'd0);
        end else begin
          exp = sb_q.pop_front();
          check($sformatf("%s_beat%0d", v.name, out_cnt),
                {29'd0, m_data, m_sof, m_eol, m_eof}, {29'd0, exp});
        end
        out_cnt++;
      end
      if (out_cnt >= target) done = 1'b1;
      cyc++;
      if (!done && cyc > 3000) begin
        check({v.name, "_timeout"}, 64'(out_cnt), 64'(target));
        done = 1'b1;
      end
    end

    check({v.name, "_beat_count"}, 64'(out_cnt), 64'(v.exp_beats));
    check({v.name, "_err_track"}, 64'(err_bad), 64'd0);
    if (v.abort_at < 0) begin
      check({v.name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
      check({v.name, "_busy_gaps"}, 64'(busy_gaps), 64'(v.exp_busy_gaps));
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      check({v.name, "_err_end"}, {63'd0, err}, {63'd0, v.exp_err});
      check({v.name, "_idle_after"}, {62'd0, busy, m_valid}, 64'd0);
    end
    if (v.stall_pix >= 0)
      check({v.name, "_stall_bubbles"}, 64'(stall_low), 64'(v.exp_stall_low));
    s_valid = 1'b0;
  endtask

  vec_t vecs[5];
  vec_t rst_vec, post_vec;

  initial begin
    vecs[0] = '{"basic",  1, 100, 1, -1, 99999, -1, -1, NBEAT,     0, 0, 1'b0};
    vecs[1] = '{"rready", 1,  50, 1, -1, 99999, -1, -1, NBEAT,     0, 0, 1'b0};
    vecs[2] = '{"stall",  1, 100, 1,  3,    58, -1, -1, NBEAT,     0, 5, 1'b0};
    vecs[3] = '{"b2b",    1, 100, 2, -1, 99999, -1, -1, 2 * NBEAT, 1, 0, 1'b0};
    vecs[4] = '{"badlast",1, 100, 1, -1, 99999,  3, -1, NBEAT,     0, 0, LC};
    rst_vec  = '{"abort", 1, 100, 1, -1, 99999, -1, 40, 40,        0, 0, 1'b0};
    post_vec = '{"post",  1, 100, 1, -1, 99999, -1, -1, NBEAT,     0, 0, 1'b0};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    err_model = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_case(vecs[i]);

    // Reset mid-frame: outputs clear immediately, next frame starts from (0,0).
    run_case(rst_vec);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    sb_q.delete();
    err_model = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_case(post_vec);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
